// File: rtl/router_pkg.sv
// Shared types for the router egress path: address/data widths, the packet
// record carried through the egress FIFO, and the egress FSM state encoding.
package router_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] source;
    logic [ADDR_W-1:0] target;
    logic [DATA_W-1:0] data;
  } packet_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } egress_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO of packet records with occupancy output. Pushes while full
// and pops while empty are ignored; DEPTH must be a power of two.
module sync_fifo
  import router_pkg::*;
#(
  parameter int WIDTH = $bits(packet_t),
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok_s, pop_ok_s;

  assign full      = (level_q == LW'(DEPTH));
  assign empty     = (level_q == LW'(0));
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign rdata     = mem_q[rd_ptr_q];
  assign level     = level_q;

  // Next-state for storage, pointers and occupancy; pointers wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // State registers; reset discards all stored packets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      level_q  <= LW'(0);
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/egress_port.sv
// Router egress port: filters fabric packets by target address, buffers them,
// and emits one single-cycle strobe per packet with an optional inter-packet gap.
module egress_port
  import router_pkg::*;
#(
  parameter int PORT_ID    = 2,
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 0,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [ADDR_W-1:0] source_in,
  input  logic [ADDR_W-1:0] target_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              in_ready,
  input  logic              out_hold,
  output logic              valid_out,
  output logic [ADDR_W-1:0] source_out,
  output logic [ADDR_W-1:0] target_out,
  output logic [DATA_W-1:0] data_out,
  output logic [LW-1:0]     level,
  output logic [7:0]        drop_cnt,
  output logic [7:0]        misroute_cnt
);

  egress_state_t state_q, state_d;
  packet_t       pkt_q, pkt_d;
  packet_t       in_pkt_s, head_s;
  logic          valid_q, valid_d;
  logic [3:0]    gap_q, gap_d;
  logic [7:0]    drop_q, drop_d;
  logic [7:0]    mis_q, mis_d;
  logic          match_s, push_s, pop_s, full_s, empty_s, start_s;

  assign in_pkt_s.source = source_in;
  assign in_pkt_s.target = target_in;
  assign in_pkt_s.data   = data_in;
  assign match_s = (target_in == ADDR_W'(PORT_ID));
  assign push_s  = valid_in & match_s;
  assign start_s = ~empty_s & ~out_hold;

  sync_fifo #(.WIDTH($bits(packet_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .wdata (in_pkt_s),
    .pop   (pop_s),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .level (level)
  );

  // Drop counters: a misroute wins over a full FIFO; both saturate.
  always_comb begin
    mis_d  = mis_q;
    drop_d = drop_q;
    if (valid_in && !match_s && (mis_q != 8'hFF)) begin
      mis_d = mis_q + 8'd1;
    end else if (push_s && full_s && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end else begin
      mis_d  = mis_q;
      drop_d = drop_q;
    end
  end

  // Output FSM; the last gap cycle may start the next pulse so the gap is exact.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pkt_d   = pkt_q;
    valid_d = 1'b0;
    pop_s   = 1'b0;
    case (state_q)
      IDLE, GAP, SEND: begin
        if ((state_q == SEND) && (GAP_CYCLES != 0)) begin
          gap_d   = 4'(GAP_CYCLES);
          state_d = GAP;
        end else if ((state_q == GAP) && (gap_q > 4'd1)) begin
          gap_d   = gap_q - 4'd1;
          state_d = GAP;
        end else if (start_s) begin
          gap_d   = 4'd0;
          pop_s   = 1'b1;
          pkt_d   = head_s;
          valid_d = 1'b1;
          state_d = SEND;
        end else begin
          gap_d   = 4'd0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        gap_d   = 4'd0;
      end
    endcase
  end

  // Registered outputs and control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gap_q   <= 4'd0;
      pkt_q   <= '{source: 4'd0, target: 4'd0, data: 8'd0};
      valid_q <= 1'b0;
      drop_q  <= 8'd0;
      mis_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      pkt_q   <= pkt_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
      mis_q   <= mis_d;
    end
  end

  assign in_ready     = ~full_s;
  assign valid_out    = valid_q;
  assign source_out   = pkt_q.source;
  assign target_out   = pkt_q.target;
  assign data_out     = pkt_q.data;
  assign drop_cnt     = drop_q;
  assign misroute_cnt = mis_q;

endmodule

// File: doc/egress_port.md
Name: egress_port

Overview:
- Switch-side egress for one router port.
- Accepts packets (source, target, data) from the switching fabric and buffers them in a FIFO.
- Emits each packet on the port output bus as a single-cycle valid_out pulse, which the port monitor samples.
- Drops misrouted packets and overflow packets, and counts both kinds of drop.

Parameters:
- PORT_ID, 2: address of this port; only packets with target_in == PORT_ID are accepted.
- DEPTH, 4: FIFO depth in packets; power of two, minimum 2.
- GAP_CYCLES, 0: idle cycles forced between consecutive valid_out pulses (0..15).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- valid_in  in  1  fabric packet valid, one cycle per packet
- source_in  in  4  packet source address
- target_in  in  4  packet target address
- data_in  in  8  packet payload
- in_ready  out  1  FIFO not full (level < DEPTH)
- out_hold  in  1  downstream hold; no new pulse starts while 1
- valid_out  out  1  single-cycle packet strobe
- source_out  out  4  source of emitted packet
- target_out  out  4  target of emitted packet
- data_out  out  8  payload of emitted packet
- level  out  $clog2(DEPTH)+1  current FIFO occupancy
- drop_cnt  out  8  overflow drops, saturating
- misroute_cnt  out  8  target-mismatch drops, saturating

Behaviour:
- Reset (async assert, sync release):
  - valid_out, source_out, target_out, data_out = 0.
  - level = 0, FIFO empty, both counters = 0, FSM = IDLE.
  - in_ready = 1.
- Ingress decision, on each edge where valid_in = 1:
  - target_in != PORT_ID -> packet dropped; misroute_cnt++ (saturates at 255). Mismatch takes priority over full.
  - target_in == PORT_ID and level == DEPTH -> packet dropped; drop_cnt++ (saturates at 255).
  - Otherwise -> packet written to FIFO tail.
- A pop on the same edge does not free space for a write: the full check uses level before the edge.
- in_ready is combinational from level. The fabric may ignore it; anything sent while full is dropped and counted.
- FSM states: IDLE, SEND, GAP.
  - IDLE: if FIFO not empty and out_hold = 0 -> pop head, register it onto the *_out fields, valid_out = 1, go to SEND.
  - SEND (one cycle):
    - valid_out returns to 0.
    - If GAP_CYCLES = 0, apply the IDLE pop rule in this same cycle, so back-to-back pulses are possible.
    - Otherwise load the gap counter = GAP_CYCLES and go to GAP.
  - GAP: decrement the counter each cycle; at 1 go to IDLE. Exactly GAP_CYCLES cycles have valid_out = 0.
- Latency: a packet written at edge N into an empty FIFO, with out_hold = 0 and the FSM idle, drives valid_out high from edge N+1 to edge N+2.
- Payload hold: source_out, target_out and data_out keep their last value until the next pop; they are not cleared when valid_out drops.
- Ordering: strict FIFO order; no reordering and no duplication.
- Simultaneous write and pop with 0 < level < DEPTH: level is unchanged.
- Pointers wrap modulo DEPTH.
- out_hold:
  - Sampled only when deciding to start a pop.
  - A pulse already started is not cancelled.
  - The gap counter keeps counting during a hold.
- Reset mid-operation: FIFO contents are discarded. After release no stale packet is emitted, and valid_out is 0 immediately on rst_n falling.

Decomposition:
- Package router_pkg:
  - ADDR_W = 4, DATA_W = 8.
  - packet_t struct {source, target, data}.
  - egress_state_t enum {IDLE, SEND, GAP}.
- Sub-module sync_fifo:
  - Parameterised by width and depth.
  - push/pop/full/empty/level.
  - Storage of packet_t, async active-low reset.
- egress_port holds the ingress filter, the counters, the FSM and the output registers.

Test Plan:
- Reset: hold rst_n = 0 -> all outputs 0, in_ready = 1, level = 0. Release, idle 10 cycles -> valid_out stays 0.
- Single packet (source=1, target=2, data=0xA5) at edge N -> one valid_out pulse at edges N+1..N+2 with source_out=1, target_out=2, data_out=0xA5; fields still hold those values at N+5.
- Misroute (target=3, data=0x11) -> no valid_out, misroute_cnt = 1, level = 0. Repeat 300 times -> misroute_cnt = 255.
- Overflow: out_hold = 1, send 5 packets with data 0x01..0x05 -> level = 4, in_ready = 0, drop_cnt = 1. Set out_hold = 0 -> four consecutive single-cycle pulses with data 0x01..0x04, then level = 0.
- Gap: GAP_CYCLES = 2, push data 0x10 and 0x20 back-to-back -> pulses for 0x10 then 0x20 separated by exactly 2 cycles with valid_out = 0.
- Reset mid-run: level = 3 with out_hold = 1, pulse rst_n low -> level = 0 and counters = 0. After release with out_hold = 0, 10 idle cycles -> no valid_out.
